// File: rtl/poly_eval_arb_if.sv
// Handshake bundle for poly_eval_arb: two requesters, one result channel and
// the coefficient write port. The arbiter takes the slave side.
interface poly_eval_arb_if #(
    parameter int W  = 5,
    parameter int XW = 2
) ();
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*XW-1:0] req_x;
    logic [2*W-1:0]  req_off;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [W-1:0]    rsp_data;
    logic            rsp_id;
    logic            cfg_we;
    logic [1:0]      cfg_idx;
    logic [W-1:0]    cfg_data;
    logic            cfg_ready;

    modport slave (
        input  req_valid, req_x, req_off, rsp_ready, cfg_we, cfg_idx, cfg_data,
        output req_ready, rsp_valid, rsp_data, rsp_id, cfg_ready
    );

    modport master (
        output req_valid, req_x, req_off, rsp_ready, cfg_we, cfg_idx, cfg_data,
        input  req_ready, rsp_valid, rsp_data, rsp_id, cfg_ready
    );
endinterface

// File: rtl/poly_eval_arb.sv
// Two-requester round-robin evaluator of a degree-3 polynomial plus offset,
// computed in Horner form on one shared multiply-add over three cycles.
module poly_eval_arb #(
    parameter int W  = 5,
    parameter int XW = 2
) (
    input logic             clk,
    input logic             rst,
    poly_eval_arb_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

    localparam logic [W-1:0] C0_RST = W'(1);
    localparam logic [W-1:0] C1_RST = W'((1 << W) - 5);
    localparam logic [W-1:0] C2_RST = W'((1 << W) - 4);
    localparam logic [W-1:0] C3_RST = W'(8);

    state_e          state_q, state_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [XW-1:0]   x_q, x_d;
    logic [W-1:0]    off_q, off_d;
    logic            id_q, id_d;
    logic            last_id_q, last_id_d;
    logic [W-1:0]    coef_q [4];
    logic [W-1:0]    coef_d [4];

    logic            grant_id;
    logic            accept;
    logic [W+XW-1:0] prod;
    logic [W-1:0]    mac_sum;

    // Tie goes to the requester that was not served last.
    assign grant_id = (bus.req_valid == 2'b11) ? ~last_id_q : bus.req_valid[1];
    assign accept   = (state_q == IDLE) && !bus.cfg_we && (|bus.req_valid);

    assign prod    = {{XW{1'b0}}, acc_q} * {{W{1'b0}}, x_q};
    assign mac_sum = prod[W-1:0] + coef_q[cnt_q] + ((cnt_q == 2'd0) ? off_q : '0);

    always_comb begin
        // NOTE: every _d starts from its _q so no path through the case leaves a
        // signal unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        off_d     = off_q;
        id_d      = id_q;
        last_id_d = last_id_q;
        coef_d    = coef_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cfg_we) begin
                    coef_d[bus.cfg_idx] = bus.cfg_data;
                end else if (accept) begin
                    x_d       = grant_id ? bus.req_x[2*XW-1:XW] : bus.req_x[XW-1:0];
                    off_d     = grant_id ? bus.req_off[2*W-1:W] : bus.req_off[W-1:0];
                    id_d      = grant_id;
                    last_id_d = grant_id;
                    acc_d     = coef_q[3];
                    cnt_d     = 2'd2;
                    state_d   = MAC;
                end
            end
            MAC: begin
                acc_d = mac_sum;
                if (cnt_q == 2'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state elements are assigned with <= so every flop samples the values
    // of the previous cycle regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            x_q       <= '0;
            off_q     <= '0;
            id_q      <= 1'b0;
            last_id_q <= 1'b1;
            // NOTE: the four coefficients are plain flops rather than a RAM, so
            // resetting them to their defaults is legal and cheap.
            coef_q[0] <= C0_RST;
            coef_q[1] <= C1_RST;
            coef_q[2] <= C2_RST;
            coef_q[3] <= C3_RST;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            off_q     <= off_d;
            id_q      <= id_d;
            last_id_q <= last_id_d;
            coef_q    <= coef_d;
        end
    end

    assign bus.req_ready = (accept && !rst) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.rsp_data  = acc_q;
    assign bus.rsp_id    = id_q;
endmodule

// File: tb/tb_poly_eval_arb.sv
// Directed bench for poly_eval_arb: a transaction-level model predicts every
// output each cycle; literal expectations pin the directed scenarios.
module tb_poly_eval_arb;
    localparam int W  = 5;
    localparam int XW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    poly_eval_arb_if #(.W(W), .XW(XW)) bus ();
    poly_eval_arb #(.W(W), .XW(XW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: no response within bound (cycle %0d)", name, cyc);
    endtask

    // Model: coefficients, round-robin pointer, busy countdown, pending result.
    int           m_c [4];
    int           m_last;
    int           m_busy;
    bit           m_has;
    logic [W-1:0] m_res;
    int           m_id;

    function automatic int m_grant();
        if (bus.req_valid == 2'b11) return (m_last == 1) ? 0 : 1;
        return bus.req_valid[1] ? 1 : 0;
    endfunction

    function automatic logic [W-1:0] poly(input int g);
        int x, off, s;
        x   = int'((bus.req_x >> (g * XW)) & 4'((1 << XW) - 1));
        off = int'((bus.req_off >> (g * W)) & 10'((1 << W) - 1));
        s   = off + m_c[0] + m_c[1] * x + m_c[2] * x * x + m_c[3] * x * x * x;
        return W'(s % (1 << W));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_c[0] <= 1;
            m_c[1] <= (1 << W) - 5;
            m_c[2] <= (1 << W) - 4;
            m_c[3] <= 8;
            m_last <= 1;
            m_busy <= 0;
            m_has  <= 1'b0;
            m_res  <= '0;
            m_id   <= 0;
        end else if (m_has) begin
            if (bus.rsp_ready) m_has <= 1'b0;
        end else if (m_busy > 0) begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) m_has <= 1'b1;
        end else if (bus.cfg_we) begin
            m_c[bus.cfg_idx] <= int'(bus.cfg_data);
        end else if (|bus.req_valid) begin
            m_id   <= m_grant();
            m_last <= m_grant();
            m_res  <= poly(m_grant());
            m_busy <= 3;
        end
    end

    always @(negedge clk) begin : compare
        logic [1:0] exp_rdy;
        bit         idle;
        idle    = !m_has && (m_busy == 0);
        exp_rdy = 2'b00;
        if (!rst && idle && !bus.cfg_we && (|bus.req_valid))
            exp_rdy = (m_grant() == 1) ? 2'b10 : 2'b01;
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        check("cfg_ready", 32'(bus.cfg_ready), 32'(idle));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(m_has));
        if (m_has) begin
            check("rsp_data", 32'(bus.rsp_data), 32'(m_res));
            check("rsp_id", 32'(bus.rsp_id), 32'(m_id));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input string name, output int c);
        c = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) timeout_fail(name);
    endtask

    task automatic wait_rsp(input string name, output int c);
        c = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) timeout_fail(name);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        timeout_fail("global_timeout");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        int a, r;
        int vals [4];
        vals = '{0, 1, 0, 0};
        rst           = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_x     = '0;
        bus.req_off   = '0;
        bus.rsp_ready = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_idx   = '0;
        bus.cfg_data  = '0;
        @(negedge clk);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_data", 32'(bus.rsp_data), 0);
        check("rst_rsp_id", 32'(bus.rsp_id), 0);
        check("rst_cfg_ready", 32'(bus.cfg_ready), 1);
        tick();
        rst = 1'b0;

        // Single request: x=3, off=0 with reset coefficients.
        bus.req_x     = {2'd0, 2'd3};
        bus.req_off   = {5'd0, 5'd0};
        bus.req_valid = 2'b01;
        wait_accept("s1_accept", a);
        tick();
        bus.req_valid = 2'b00;
        wait_rsp("s1_rsp", r);
        check("s1_latency", 32'(r - a), 4);
        check("s1_data", 32'(bus.rsp_data), 6);
        check("s1_id", 32'(bus.rsp_id), 0);
        tick();

        // Both requesters held valid after reset.
        do_reset();
        bus.req_x     = {2'd2, 2'd1};
        bus.req_off   = {5'd0, 5'd2};
        bus.req_valid = 2'b11;
        wait_accept("s2_acc0", a);
        check("s2_grant_first", 32'(bus.req_ready), 1);
        wait_rsp("s2_rsp0", r);
        check("s2_data0", 32'(bus.rsp_data), 2);
        check("s2_id0", 32'(bus.rsp_id), 0);
        wait_accept("s2_acc1", a);
        check("s2_grant_second", 32'(bus.req_ready), 2);
        wait_rsp("s2_rsp1", r);
        check("s2_data1", 32'(bus.rsp_data), 7);
        check("s2_id1", 32'(bus.rsp_id), 1);
        wait_accept("s2_acc2", a);
        check("s2_grant_third", 32'(bus.req_ready), 1);
        tick();
        bus.req_valid = 2'b00;
        wait_rsp("s2_rsp2", r);
        check("s2_data2", 32'(bus.rsp_data), 2);
        tick();

        // Config write then evaluate; a write during MAC must be ignored.
        bus.cfg_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.cfg_idx  = 2'(i);
            bus.cfg_data = W'(vals[i]);
            tick();
        end
        bus.cfg_we    = 1'b0;
        bus.req_x     = {2'd0, 2'd3};
        bus.req_off   = {5'd0, 5'd4};
        bus.req_valid = 2'b01;
        wait_accept("s3_accept", a);
        tick();
        bus.req_valid = 2'b00;
        bus.cfg_we    = 1'b1;
        bus.cfg_idx   = 2'd0;
        bus.cfg_data  = 5'd31;
        tick();
        bus.cfg_we    = 1'b0;
        wait_rsp("s3_rsp", r);
        check("s3_data", 32'(bus.rsp_data), 7);
        tick();
        bus.req_valid = 2'b01;
        wait_accept("s3_accept2", a);
        tick();
        bus.req_valid = 2'b00;
        wait_rsp("s3_rsp2", r);
        check("s3_data_after_ignored_cfg", 32'(bus.rsp_data), 7);
        tick();

        // Backpressure in DONE with another requester waiting.
        bus.rsp_ready = 1'b0;
        bus.req_x     = {2'd1, 2'd0};
        bus.req_off   = '0;
        bus.req_valid = 2'b10;
        wait_accept("s4_accept", a);
        tick();
        bus.req_valid = 2'b01;
        wait_rsp("s4_rsp", r);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("s4_hold_valid", 32'(bus.rsp_valid), 1);
            check("s4_hold_data", 32'(bus.rsp_data), 1);
            check("s4_hold_id", 32'(bus.rsp_id), 1);
            check("s4_hold_req_ready", 32'(bus.req_ready), 0);
        end
        tick();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("s4_release_valid", 32'(bus.rsp_valid), 1);
        @(negedge clk);
        check("s4_single_transfer", 32'(bus.rsp_valid), 0);
        check("s4_next_grant", 32'(bus.req_ready), 1);
        tick();
        bus.req_valid = 2'b00;
        wait_rsp("s4_rsp2", r);
        check("s4_data2", 32'(bus.rsp_data), 0);
        tick();

        // Reset in cycle N+2 of an evaluation.
        bus.req_x     = {2'd0, 2'd3};
        bus.req_off   = '0;
        bus.req_valid = 2'b01;
        wait_accept("s5_accept", a);
        tick();
        bus.req_valid = 2'b00;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("s5_rst_valid", 32'(bus.rsp_valid), 0);
        check("s5_rst_cfg_ready", 32'(bus.cfg_ready), 1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("s5_discarded", 32'(bus.rsp_valid), 0);
        end
        tick();
        bus.req_valid = 2'b01;
        wait_accept("s5_accept2", a);
        tick();
        bus.req_valid = 2'b00;
        wait_rsp("s5_rsp", r);
        check("s5_data_default_coefs", 32'(bus.rsp_data), 6);
        tick();

        // Config write and request in the same IDLE cycle.
        bus.cfg_we    = 1'b1;
        bus.cfg_idx   = 2'd0;
        bus.cfg_data  = 5'd5;
        bus.req_valid = 2'b01;
        @(negedge clk);
        check("s6_cfg_wins", 32'(bus.req_ready), 0);
        check("s6_cfg_ready", 32'(bus.cfg_ready), 1);
        tick();
        bus.cfg_we = 1'b0;
        @(negedge clk);
        check("s6_accept_next", 32'(bus.req_ready), 1);
        tick();
        bus.req_valid = 2'b00;
        wait_rsp("s6_rsp", r);
        check("s6_data", 32'(bus.rsp_data), 10);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
